// File: rtl/phy_lane_feeder_pkg.sv
// Shared constants for the dual-lane PHY feeder: default widths, depths and
// occupancy thresholds, plus the pointer-width helper used by every lane.
package phy_lane_feeder_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int DEPTH_DEF     = 8;
    localparam int AF_THRESH_DEF = 6;
    localparam int AE_THRESH_DEF = 2;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int PTR_W = ptr_width(DEPTH_DEF);

endpackage

// File: rtl/phy_lane_feeder_lane_fifo.sv
// Single-lane FIFO feeding one PHY lane: registered output stage, occupancy
// flags decoded from the registered count, and a sticky overflow flag.
module lane_fifo
    import phy_lane_feeder_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF,
    parameter int AE_THRESH = AE_THRESH_DEF,
    parameter int PW        = ptr_width(DEPTH),
    parameter int CW        = PW + 1
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              valid_out_reg;
    logic              overflow_reg;
    logic              pop;
    logic              push_ok;

    // Flags come straight from the registered count, so they carry no extra latency.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == CW'(DEPTH));
    assign almost_full  = (count_reg >= CW'(AF_THRESH));
    assign almost_empty = (count_reg <= CW'(AE_THRESH));

    // A full FIFO can still take a byte when the same edge frees a slot.
    assign pop     = pop_en && !empty;
    assign push_ok = push && (!full || pop);

    assign data_out  = data_out_reg;
    assign valid_out = valid_out_reg;
    assign overflow  = overflow_reg;
    assign count     = count_reg;

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk_f) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    // Pointer advance; both wrap naturally at DEPTH.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Registered output stage; data holds its last value when idle.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            valid_out_reg <= pop;
            if (pop) begin
                data_out_reg <= mem[rd_ptr_reg];
            end
        end
    end

    // Occupancy tracking; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky record of any dropped write; only reset clears it.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (push && !push_ok) begin
            overflow_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/phy_lane_feeder.sv
// Dual-lane ingress buffer ahead of the PHY: two independent lane FIFOs
// sharing only the drain enable. No alignment between lanes is attempted.
module phy_lane_feeder
    import phy_lane_feeder_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF,
    parameter int AE_THRESH = AE_THRESH_DEF,
    parameter int CW        = ptr_width(DEPTH) + 1
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic              push_0,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic              push_1,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              pop_en,
    output logic [DATA_W-1:0] data_out_0,
    output logic              valid_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_out_1,
    output logic              full_0,
    output logic              full_1,
    output logic              empty_0,
    output logic              empty_1,
    output logic              almost_full_0,
    output logic              almost_full_1,
    output logic              almost_empty_0,
    output logic              almost_empty_1,
    output logic              overflow_0,
    output logic              overflow_1,
    output logic [CW-1:0]     count_0,
    output logic [CW-1:0]     count_1
);

    localparam int LANES = 2;

    logic              push_v     [LANES];
    logic [DATA_W-1:0] data_in_v  [LANES];
    logic [DATA_W-1:0] data_out_v [LANES];
    logic              valid_v    [LANES];
    logic              full_v     [LANES];
    logic              empty_v    [LANES];
    logic              af_v       [LANES];
    logic              ae_v       [LANES];
    logic              ovf_v      [LANES];
    logic [CW-1:0]     count_v    [LANES];

    assign push_v[0]    = push_0;
    assign push_v[1]    = push_1;
    assign data_in_v[0] = data_in_0;
    assign data_in_v[1] = data_in_1;

    assign data_out_0     = data_out_v[0];
    assign data_out_1     = data_out_v[1];
    assign valid_out_0    = valid_v[0];
    assign valid_out_1    = valid_v[1];
    assign full_0         = full_v[0];
    assign full_1         = full_v[1];
    assign empty_0        = empty_v[0];
    assign empty_1        = empty_v[1];
    assign almost_full_0  = af_v[0];
    assign almost_full_1  = af_v[1];
    assign almost_empty_0 = ae_v[0];
    assign almost_empty_1 = ae_v[1];
    assign overflow_0     = ovf_v[0];
    assign overflow_1     = ovf_v[1];
    assign count_0        = count_v[0];
    assign count_1        = count_v[1];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            lane_fifo #(
                .DATA_W   (DATA_W),
                .DEPTH    (DEPTH),
                .AF_THRESH(AF_THRESH),
                .AE_THRESH(AE_THRESH),
                .PW       (CW - 1),
                .CW       (CW)
            ) u_lane (
                .clk_f       (clk_f),
                .reset       (reset),
                .push        (push_v[gi]),
                .data_in     (data_in_v[gi]),
                .pop_en      (pop_en),
                .data_out    (data_out_v[gi]),
                .valid_out   (valid_v[gi]),
                .full        (full_v[gi]),
                .empty       (empty_v[gi]),
                .almost_full (af_v[gi]),
                .almost_empty(ae_v[gi]),
                .overflow    (ovf_v[gi]),
                .count       (count_v[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_phy_lane_feeder.sv
// Directed bench for phy_lane_feeder: reset state, latency, fill/overflow,
// push-while-full-and-popping, pointer wrap, and asynchronous mid-burst reset.
module tb_phy_lane_feeder;

    logic       clk_f = 1'b0;
    logic       reset;
    logic       push_0, push_1, pop_en;
    logic [7:0] data_in_0, data_in_1;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1;
    logic       full_0, full_1, empty_0, empty_1;
    logic       almost_full_0, almost_full_1, almost_empty_0, almost_empty_1;
    logic       overflow_0, overflow_1;
    logic [3:0] count_0, count_1;

    int checks = 0;
    int errors = 0;

    phy_lane_feeder dut (
        .clk_f         (clk_f),
        .reset         (reset),
        .push_0        (push_0),
        .data_in_0     (data_in_0),
        .push_1        (push_1),
        .data_in_1     (data_in_1),
        .pop_en        (pop_en),
        .data_out_0    (data_out_0),
        .valid_out_0   (valid_out_0),
        .data_out_1    (data_out_1),
        .valid_out_1   (valid_out_1),
        .full_0        (full_0),
        .full_1        (full_1),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .almost_full_0 (almost_full_0),
        .almost_full_1 (almost_full_1),
        .almost_empty_0(almost_empty_0),
        .almost_empty_1(almost_empty_1),
        .overflow_0    (overflow_0),
        .overflow_1    (overflow_1),
        .count_0       (count_0),
        .count_1       (count_1)
    );

    always #5 clk_f = ~clk_f;

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; push_0 = 0; push_1 = 0; pop_en = 0; data_in_0 = 0; data_in_1 = 0;
        #12;
        checks++; if ({valid_out_0, valid_out_1} !== 2'b00) begin errors++; $display("FAIL rst_valid got %b expected 00", {valid_out_0, valid_out_1}); end
        checks++; if ({empty_0, empty_1, almost_empty_0, almost_empty_1} !== 4'b1111) begin errors++; $display("FAIL rst_empty got %b expected 1111", {empty_0, empty_1, almost_empty_0, almost_empty_1}); end
        checks++; if ({full_0, full_1, almost_full_0, almost_full_1, overflow_0, overflow_1} !== 6'b0) begin errors++; $display("FAIL rst_full_ovf got %b expected 000000", {full_0, full_1, almost_full_0, almost_full_1, overflow_0, overflow_1}); end
        checks++; if ({count_0, count_1, data_out_0, data_out_1} !== 24'h0) begin errors++; $display("FAIL rst_count_data got %h expected 000000", {count_0, count_1, data_out_0, data_out_1}); end
        tick();
        reset = 1'b0;
        pop_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({valid_out_0, valid_out_1, empty_0, empty_1, overflow_0, overflow_1, count_0, count_1} !== {6'b001100, 8'h00}) begin
                errors++; $display("FAIL idle cycle %0d got v=%b%b e=%b%b o=%b%b c=%0d/%0d expected idle empty", i, valid_out_0, valid_out_1, empty_0, empty_1, overflow_0, overflow_1, count_0, count_1);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_latency();
        logic [7:0] din [5];
        logic       exp_v [5];
        logic [7:0] exp_d [5];
        logic [3:0] exp_c [5];
        din   = '{8'hBC, 8'h01, 8'h02, 8'h00, 8'h00};
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d = '{8'h00, 8'hBC, 8'h01, 8'h02, 8'h02};
        exp_c = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
        pop_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_0 = (i < 3); data_in_0 = din[i];
            tick();
            $display("latency edge %0d: valid_out_0=%b data_out_0=%h count_0=%0d", i, valid_out_0, data_out_0, count_0);
            checks++; if (valid_out_0 !== exp_v[i]) begin errors++; $display("FAIL lat_valid edge %0d got %b expected %b", i, valid_out_0, exp_v[i]); end
            checks++; if (data_out_0 !== exp_d[i]) begin errors++; $display("FAIL lat_data edge %0d got %h expected %h", i, data_out_0, exp_d[i]); end
            checks++; if (count_0 !== exp_c[i]) begin errors++; $display("FAIL lat_count edge %0d got %0d expected %0d", i, count_0, exp_c[i]); end
            checks++; if (valid_out_1 !== 1'b0) begin errors++; $display("FAIL lat_lane1_idle edge %0d got %b expected 0", i, valid_out_1); end
        end
        push_0 = 1'b0;
    endtask

    task automatic test_fill_overflow();
        int n;
        pop_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_1 = 1'b1; data_in_1 = 8'h10 + 8'(i);
            tick();
            n = i + 1;
            $display("fill lane1 push %h: count_1=%0d full_1=%b af_1=%b ovf_1=%b", data_in_1, count_1, full_1, almost_full_1, overflow_1);
            checks++; if (count_1 !== 4'((n > 8) ? 8 : n)) begin errors++; $display("FAIL fill_count push %0d got %0d expected %0d", n, count_1, (n > 8) ? 8 : n); end
            checks++; if (full_1 !== (n >= 8)) begin errors++; $display("FAIL fill_full push %0d got %b expected %b", n, full_1, n >= 8); end
            checks++; if (almost_full_1 !== (n >= 6)) begin errors++; $display("FAIL fill_af push %0d got %b expected %b", n, almost_full_1, n >= 6); end
            checks++; if (overflow_1 !== (n >= 9)) begin errors++; $display("FAIL fill_ovf push %0d got %b expected %b", n, overflow_1, n >= 9); end
            checks++; if (valid_out_1 !== 1'b0) begin errors++; $display("FAIL fill_no_drain push %0d got %b expected 0", n, valid_out_1); end
        end
        push_1 = 1'b0;
        pop_en = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            $display("drain lane1: valid_out_1=%b data_out_1=%h count_1=%0d", valid_out_1, data_out_1, count_1);
            if (j <= 8) begin
                checks++; if ({valid_out_1, data_out_1} !== {1'b1, 8'h10 + 8'(j - 1)}) begin errors++; $display("FAIL drain_data pop %0d got v=%b d=%h expected v=1 d=%h", j, valid_out_1, data_out_1, 8'h10 + 8'(j - 1)); end
                checks++; if (almost_empty_1 !== ((8 - j) <= 2)) begin errors++; $display("FAIL drain_ae pop %0d got %b expected %b", j, almost_empty_1, (8 - j) <= 2); end
            end else begin
                checks++; if ({valid_out_1, empty_1, count_1, overflow_1} !== {2'b01, 4'd0, 1'b1}) begin errors++; $display("FAIL drain_end got v=%b e=%b c=%0d o=%b expected v=0 e=1 c=0 o=1", valid_out_1, empty_1, count_1, overflow_1); end
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        pop_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_0 = 1'b1; data_in_0 = 8'h20 + 8'(i);
            tick();
        end
        checks++; if ({full_0, count_0} !== {1'b1, 4'd8}) begin errors++; $display("FAIL fpp_prefill got full=%b count=%0d expected full=1 count=8", full_0, count_0); end
        pop_en = 1'b1; data_in_0 = 8'hAA;
        tick();
        push_0 = 1'b0;
        $display("fpp push AA while full: count_0=%0d data_out_0=%h", count_0, data_out_0);
        checks++; if (count_0 !== 4'd8) begin errors++; $display("FAIL fpp_count got %0d expected 8", count_0); end
        checks++; if (overflow_0 !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b expected 0", overflow_0); end
        checks++; if ({valid_out_0, data_out_0} !== 9'h120) begin errors++; $display("FAIL fpp_first got v=%b d=%h expected v=1 d=20", valid_out_0, data_out_0); end
        for (int j = 1; j <= 8; j++) begin
            tick();
            exp = (j == 8) ? 8'hAA : 8'h20 + 8'(j);
            $display("fpp drain: data_out_0=%h", data_out_0);
            checks++; if ({valid_out_0, data_out_0} !== {1'b1, exp}) begin errors++; $display("FAIL fpp_order pop %0d got v=%b d=%h expected v=1 d=%h", j, valid_out_0, data_out_0, exp); end
        end
        tick();
        checks++; if ({valid_out_0, empty_0, overflow_0} !== 3'b010) begin errors++; $display("FAIL fpp_end got v=%b e=%b o=%b expected 0 1 0", valid_out_0, empty_0, overflow_0); end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        pop_en = 1'b1;
        for (int i = 0; i < 22; i++) begin
            push_0 = (i < 20); push_1 = (i < 20);
            data_in_0 = 8'(i); data_in_1 = ~8'(i);
            tick();
            e = 8'(i - 1);
            if (i >= 1 && i <= 20) begin
                $display("wrap step %0d: lane0=%h lane1=%h", i, data_out_0, data_out_1);
                checks++; if ({valid_out_0, data_out_0} !== {1'b1, e}) begin errors++; $display("FAIL wrap_lane0 step %0d got v=%b d=%h expected v=1 d=%h", i, valid_out_0, data_out_0, e); end
                checks++; if ({valid_out_1, data_out_1} !== {1'b1, ~e}) begin errors++; $display("FAIL wrap_lane1 step %0d got v=%b d=%h expected v=1 d=%h", i, valid_out_1, data_out_1, ~e); end
            end else if (i == 21) begin
                checks++; if ({valid_out_0, valid_out_1} !== 2'b00) begin errors++; $display("FAIL wrap_tail got %b expected 00", {valid_out_0, valid_out_1}); end
            end
            checks++; if ({count_0, count_1} !== ((i < 20) ? 8'h11 : 8'h00)) begin errors++; $display("FAIL wrap_count step %0d got %0d/%0d expected %0d", i, count_0, count_1, (i < 20) ? 1 : 0); end
        end
        push_0 = 1'b0; push_1 = 1'b0;
    endtask

    task automatic test_async_reset();
        logic       exp_v [4];
        logic [7:0] exp_d [4];
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b0};
        exp_d = '{8'h00, 8'h55, 8'h66, 8'h66};
        pop_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_0 = 1'b1; data_in_0 = 8'h30 + 8'(i);
            tick();
        end
        push_0 = 1'b0; pop_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if ({count_0, valid_out_0, overflow_0, data_out_0} !== {4'd5, 2'b11, 8'h32}) begin errors++; $display("FAIL ar_pre got c=%0d v=%b o=%b d=%h expected c=5 v=1 o=1 d=32", count_0, valid_out_0, overflow_0, data_out_0); end
        #2 reset = 1'b1;
        #1;
        $display("async reset mid-cycle: valid_out_0=%b count_0=%0d overflow_0=%b", valid_out_0, count_0, overflow_0);
        checks++; if ({valid_out_0, count_0, overflow_0, empty_0, data_out_0} !== {1'b0, 4'd0, 2'b01, 8'h00}) begin errors++; $display("FAIL ar_clear got v=%b c=%0d o=%b e=%b d=%h expected v=0 c=0 o=0 e=1 d=00", valid_out_0, count_0, overflow_0, empty_0, data_out_0); end
        checks++; if (overflow_1 !== 1'b0) begin errors++; $display("FAIL ar_clear_lane1_ovf got %b expected 0", overflow_1); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_0 = (i < 2); data_in_0 = (i == 0) ? 8'h55 : 8'h66;
            tick();
            $display("post-reset edge %0d: valid_out_0=%b data_out_0=%h", i, valid_out_0, data_out_0);
            checks++; if ({valid_out_0, data_out_0} !== {exp_v[i], exp_d[i]}) begin errors++; $display("FAIL ar_post edge %0d got v=%b d=%h expected v=%b d=%h", i, valid_out_0, data_out_0, exp_v[i], exp_d[i]); end
        end
        push_0 = 1'b0;
        checks++; if ({count_0, empty_0, overflow_0} !== {4'd0, 2'b10}) begin errors++; $display("FAIL ar_final got c=%0d e=%b o=%b expected c=0 e=1 o=0", count_0, empty_0, overflow_0); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
